// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - framebuffer memory port arbiter with double-buffer swap control
module fb_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [15:0] wr_px,
  input  logic [23:0] wr_rgb,
  output logic        wr_gnt,
  input  logic        rd_req,
  input  logic [15:0] rd_px,
  output logic        rd_gnt,
  output logic        rd_valid,
  output logic [23:0] rd_rgb,
  input  logic        dfb,
  input  logic        vblank,
  output logic        fb_busy,
  output logic        front_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VB = 2'd1;
  localparam logic [1:0] SWAP    = 2'd2;

  logic [1:0]  state;
  logic [2:0]  starve_cnt;
  logic        vblank_q;
  logic [23:0] rd_rgb_q;
  logic        force_wr;

  // Busy rises in the same cycle as dfb so the sprite engine stalls without a bubble.
  assign fb_busy  = rst_n & ((state != IDLE) | dfb);
  assign force_wr = (starve_cnt == 3'd4);

  assign wr_gnt    = wr_req & ~fb_busy & (~rd_req | force_wr);
  assign rd_gnt    = rd_req & ~wr_gnt;
  assign mem_en    = rd_gnt | wr_gnt;
  assign mem_we    = wr_gnt;
  assign mem_addr  = wr_gnt ? {~front_sel, wr_px} : {front_sel, rd_px};
  assign mem_wdata = wr_rgb;
  assign rd_rgb    = rd_valid ? mem_rdata : rd_rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      front_sel  <= 1'b0;
      starve_cnt <= 3'd0;
      vblank_q   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_rgb_q   <= 24'd0;
    end else begin
      vblank_q <= vblank;
      rd_valid <= rd_gnt;
      if (rd_valid)
        rd_rgb_q <= mem_rdata;

      // Stalled cycles during a swap are not the read path's fault, so they do not count.
      if (wr_gnt)
        starve_cnt <= 3'd0;
      else if (wr_req && !fb_busy)
        starve_cnt <= starve_cnt + 3'd1;

      case (state)
        IDLE:    if (dfb) state <= WAIT_VB;
        WAIT_VB: if (vblank && !vblank_q) state <= SWAP;
        SWAP: begin
          front_sel <= ~front_sel;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - scoreboard bench for fb_port_arbiter
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_px = '0;
  logic [23:0] wr_rgb = '0;
  logic        wr_gnt;
  logic        rd_req = 1'b0;
  logic [15:0] rd_px = '0;
  logic        rd_gnt;
  logic        rd_valid;
  logic [23:0] rd_rgb;
  logic        dfb = 1'b0;
  logic        vblank = 1'b0;
  logic        fb_busy;
  logic        front_sel;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_px(wr_px), .wr_rgb(wr_rgb), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_px(rd_px), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_rgb(rd_rgb),
    .dfb(dfb), .vblank(vblank), .fb_busy(fb_busy), .front_sel(front_sel),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] init_val(input logic [16:0] a);
    return 24'hFFFFFF ^ ({7'd0, a} * 24'h009E37);
  endfunction

  // Synchronous memory seen by the DUT
  logic [23:0] dmem[int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= dmem.exists(int'(mem_addr)) ? dmem[int'(mem_addr)] : init_val(mem_addr);
    end
  end

  typedef struct { bit busy; bit front; bit wg; bit rg; bit rv; } status_t;
  typedef struct { bit we; logic [16:0] addr; logic [23:0] wdata; } acc_t;
  status_t     sq[$];
  acc_t        aq[$];
  logic [23:0] rq[$];

  // Reference model: swap progress as a phase number, starvation as a count of denied cycles
  int          phase = 0;
  bit          m_front = 0;
  int          m_starve = 0;
  bit          m_vbprev = 0;
  bit          m_prev_rg = 0;
  bit          last_wg = 0;
  logic [23:0] mmem[int];

  function automatic void model_step();
    bit busy, wg, rg, rise;
    logic [16:0] ad;
    status_t s;
    if (!rst_n) begin
      phase = 0; m_front = 0; m_starve = 0; m_vbprev = 0; m_prev_rg = 0;
    end
    busy = rst_n && (phase != 0 || dfb);
    wg   = wr_req && !busy && (!rd_req || m_starve >= 4);
    rg   = rd_req && !wg;
    s = '{busy, m_front, wg, rg, m_prev_rg};
    sq.push_back(s);
    if (wg) begin
      ad = {~m_front, wr_px};
      aq.push_back('{1'b1, ad, wr_rgb});
      mmem[int'(ad)] = wr_rgb;
    end else if (rg) begin
      ad = {m_front, rd_px};
      aq.push_back('{1'b0, ad, 24'd0});
      if (rst_n) rq.push_back(mmem.exists(int'(ad)) ? mmem[int'(ad)] : init_val(ad));
    end
    last_wg = wg;
    if (!rst_n) return;
    if (wg) m_starve = 0;
    else if (wr_req && !busy) m_starve++;
    m_prev_rg = rg;
    rise = vblank && !m_vbprev;
    m_vbprev = vblank;
    case (phase)
      0: if (dfb) phase = 1;
      1: if (rise) phase = 2;
      default: begin m_front = !m_front; phase = 0; end
    endcase
  endfunction

  task automatic drive(input bit r, input bit wq, input logic [15:0] wp, input logic [23:0] wc,
                       input bit rdq, input logic [15:0] rp, input bit d, input bit vb);
    @(negedge clk);
    rst_n = r; wr_req = wq; wr_px = wp; wr_rgb = wc;
    rd_req = rdq; rd_px = rp; dfb = d; vblank = vb;
    model_step();
  endtask

  // Monitor: compares the DUT against the queued expectations every cycle
  initial begin
    status_t     s;
    acc_t        a;
    logic [23:0] e;
    logic [23:0] last_rgb = 24'd0;
    forever begin
      @(negedge clk);
      #3;
      if (sq.size() == 0) continue;
      s = sq.pop_front();
      check("fb_busy", fb_busy, s.busy);
      check("front_sel", front_sel, s.front);
      check("wr_gnt", wr_gnt, s.wg);
      check("rd_gnt", rd_gnt, s.rg);
      check("rd_valid", rd_valid, s.rv);
      check("mem_en", mem_en, s.wg | s.rg);
      if (mem_en || s.wg || s.rg) begin
        if (aq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL access_queue: got mem_en=%0b expected no access", mem_en);
        end else begin
          a = aq.pop_front();
          check("mem_we", mem_we, a.we);
          check("mem_addr", mem_addr, a.addr);
          if (a.we) check("mem_wdata", mem_wdata, a.wdata);
        end
      end
      if (!rst_n) last_rgb = 24'd0;
      if (rd_valid || s.rv) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL read_queue: got rd_valid=%0b expected no read data", rd_valid);
        end else begin
          e = rq.pop_front();
          check("rd_rgb", rd_rgb, e);
          last_rgb = e;
        end
      end else begin
        check("rd_rgb_hold", rd_rgb, last_rgb);
      end
    end
  end

  task automatic reset_pulse(input bit vb);
    drive(1, 0, 0, 0, 0, 0, 0, vb);
    drive(0, 0, 0, 0, 0, 0, 0, vb);
    #1;
    check("rst_fb_busy", fb_busy, 1'b0);
    check("rst_front_sel", front_sel, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_rgb", rd_rgb, 24'd0);
    drive(0, 0, 0, 0, 0, 0, 0, vb);
    drive(1, 0, 0, 0, 0, 0, 0, vb);
  endtask

  initial begin
    bit          wq = 0;
    logic [15:0] wp = '0;
    logic [23:0] wc = '0;
    bit          vb = 0;
    int          vbcnt = 5;

    reset_pulse(0);

    // Write alone goes straight to the back bank
    drive(1, 1, 16'h0102, 24'hABCDEF, 0, 0, 0, 0);
    #1;
    check("d_wr_gnt", wr_gnt, 1'b1);
    check("d_mem_we", mem_we, 1'b1);
    check("d_mem_addr", mem_addr, 17'h10102);

    // Reads win four times, then the starved write gets one cycle
    for (int i = 0; i < 7; i++) begin
      drive(1, (i <= 4), 16'h0505, 24'h00FF00, 1, 16'(i + 1), 0, 0);
      #1;
      check("d_starve_wr", wr_gnt, (i == 4));
      check("d_starve_rd", rd_gnt, (i != 4));
    end

    drive(1, 0, 0, 0, 1, 16'h0000, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("d_rd_valid", rd_valid, 1'b1);
    check("d_rd_rgb", rd_rgb, 24'hFFFFFF);

    // Reset during WAIT_VB abandons the swap
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
    reset_pulse(0);

    // Full swap with a write held pending throughout
    drive(1, 1, 16'h0A0A, 24'h111111, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 16'h0A0A, 24'h111111, 0, 0, 0, 0);
      #1;
      check("d_busy_wait", fb_busy, 1'b1);
      check("d_wr_blocked", wr_gnt, 1'b0);
    end
    drive(1, 1, 16'h0A0A, 24'h111111, 0, 0, 0, 1);
    drive(1, 1, 16'h0A0A, 24'h111111, 0, 0, 0, 1);
    #1;
    check("d_swap_front_old", front_sel, 1'b0);
    check("d_swap_busy", fb_busy, 1'b1);
    drive(1, 1, 16'h0A0A, 24'h111111, 0, 0, 0, 1);
    #1;
    check("d_swap_front_new", front_sel, 1'b1);
    check("d_swap_done", fb_busy, 1'b0);

    // vblank already high at dfb, second dfb ignored
    drive(1, 0, 0, 0, 1, 16'h0303, 1, 1);
    drive(1, 0, 0, 0, 1, 16'h0303, 0, 1);
    drive(1, 0, 0, 0, 1, 16'h0303, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("d_no_early_swap", front_sel, 1'b1);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 1, 16'(i), 0, 1);
    #1;
    check("d_one_toggle", front_sel, 1'b0);
    check("d_idle_after", fb_busy, 1'b0);

    // Randomized traffic
    vb = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset_pulse(vb);
        wq = 0;
      end
      if (!wq || last_wg) begin
        wq = ($urandom_range(0, 2) != 0);
        wp = 16'($urandom);
        wc = 24'($urandom);
      end
      if (vbcnt == 0) begin
        vb = !vb;
        vbcnt = $urandom_range(3, 30);
      end else begin
        vbcnt--;
      end
      drive(1, wq, wp, wc, ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 63)),
            ($urandom_range(0, 24) == 0), vb);
    end

    drive(1, 0, 0, 0, 0, 0, 0, vb);
    drive(1, 0, 0, 0, 0, 0, 0, vb);
    @(negedge clk);
    #4;
    check("status_queue_drained", sq.size(), 0);
    check("access_queue_drained", aq.size(), 0);
    check("read_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
